conv_param_mac: RTL and testbench
=================================

CONV_PARAM_MAC -- requirements
Module: conv_param_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH_X, default 8: signed X sample width.
REQ-002 SHALL have parameter DATA_WIDTH_F, default 8: signed filter tap width.
REQ-003 SHALL have parameter X_SIZE, default 128: samples per X vector.
REQ-004 SHALL have parameter F_SIZE, default 32: taps per filter.
REQ-005 SHALL have parameter P, default 4: multipliers used per cycle; F_SIZE % P == 0, C = F_SIZE/P.
REQ-006 SHALL have parameter ACC_SIZE, default 21: output width.
REQ-007 SHALL have parameter SATURATE, default 0: 1 = clamp output, 0 = two's-complement wrap.
REQ-008 SHALL have parameter KEEP_F, default 0: 1 = filter retained across vectors.
REQ-009 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-010 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-011 SHALL have ports s_valid_x in 1, s_ready_x out 1, s_data_in_x in DATA_WIDTH_X signed: X stream.
REQ-012 SHALL have ports s_valid_f in 1, s_ready_f out 1, s_data_in_f in DATA_WIDTH_F signed: filter stream, f[0] first.
REQ-013 SHALL have ports m_valid_y out 1, m_ready_y in 1, m_data_out_y out ACC_SIZE signed: Y stream.
REQ-014 SHALL have port y_last, output, 1: high with the final Y of a vector.

Function
REQ-015 SHALL compute y[k] = sum over i of x[k+i]*f[i], for i = 0..F_SIZE-1 and k = 0..X_SIZE-F_SIZE, giving X_SIZE-F_SIZE+1 outputs per vector.
REQ-016 SHALL transfer on any stream only in cycles where valid and ready are both high; the X and F streams SHALL load concurrently and independently.
REQ-017 SHALL keep s_ready_f high while fewer than F_SIZE taps are stored, and low otherwise.
REQ-018 SHALL keep s_ready_x high only in state LOAD with window count < F_SIZE.
REQ-019 SHALL hold X in an F_SIZE-entry shift window; each accepted sample enters at the newest end.
REQ-020 SHALL implement FSM states LOAD, COMPUTE, OUTPUT:
- LOAD -> COMPUTE on the edge where window count == F_SIZE and filter count == F_SIZE.
- COMPUTE -> OUTPUT after exactly C cycles.
- OUTPUT -> LOAD on the Y handshake.
REQ-021 SHALL, in COMPUTE, add P products per cycle to a full-precision accumulator of width DATA_WIDTH_X+DATA_WIDTH_F+clog2(F_SIZE), cleared on COMPUTE entry.
REQ-022 SHALL raise m_valid_y C+1 rising edges after the edge that completed both window and filter, with no further delay.
REQ-023 SHALL hold m_data_out_y, y_last and m_valid_y stable while m_valid_y=1 and m_ready_y=0.
REQ-024 SHALL convert the accumulator to ACC_SIZE by clamping to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1] when SATURATE=1, and by truncating to the low ACC_SIZE bits when SATURATE=0.
REQ-025 SHALL, on a non-last Y handshake, reduce window count to F_SIZE-1 so that exactly one new sample is accepted before the next COMPUTE.
REQ-026 SHALL, on the last Y handshake (y_last=1):
- reset window count to 0;
- if KEEP_F=0, clear filter count so s_ready_f rises next cycle;
- if KEEP_F=1, keep the taps and keep s_ready_f low.
REQ-027 SHALL ignore s_valid_x and s_valid_f while the corresponding ready is low, and SHALL not lose or duplicate samples under arbitrary valid/ready stalls.

Reset
REQ-028 SHALL, while reset_n=0 and independent of clk, force state LOAD, both counts 0, accumulator 0, m_valid_y=0, y_last=0 and m_data_out_y=0.
REQ-029 SHALL, during reset, drive s_ready_f=1 and s_ready_x=1 (counts are 0); traffic presented during reset SHALL be ignored.
REQ-030 SHALL, on reset_n assertion in any state including mid-COMPUTE or mid-OUTPUT stall, abandon the vector with no partial Y emitted afterwards.

Verification (X_SIZE=8, F_SIZE=4, P=2, ACC_SIZE=16 unless noted)
REQ-031 SHALL cover basic: x=1..8, f=1,1,1,1, m_ready_y=1 -> Y = 10,14,18,22,26; y_last only on 26.
REQ-032 SHALL cover latency with P=4 (C=1): all data preloaded -> m_valid_y rises 2 edges after the 4th x handshake; with P=2 -> 3 edges.
REQ-033 SHALL cover backpressure: m_ready_y=0 for 10 cycles on the first Y -> m_data_out_y held at 10 and s_ready_x=0 throughout; the remaining outputs are correct after release.
REQ-034 SHALL cover arithmetic: x=127 and f=127 everywhere -> SATURATE=1 gives Y=32767 every output; SATURATE=0 gives Y=-1020 (64516 wrapped).
REQ-035 SHALL cover filter retention: with KEEP_F=1, a second vector x=1..8 sent with no F traffic -> Y = 10..26 again and s_ready_f stays 0; with KEEP_F=0 -> s_ready_f=1 after y_last.
REQ-036 SHALL cover mid-operation reset: reset_n pulsed low during COMPUTE -> all outputs 0 immediately; a fresh vector then produces the REQ-031 results.

Source files
------------

// File: rtl/conv_param_mac.sv
// conv_param_mac: streaming 1-D convolution engine.
// Loads an F_SIZE-tap filter and slides an F_SIZE-sample window over each
// X_SIZE-sample vector, producing X_SIZE-F_SIZE+1 outputs per vector using
// P multipliers per cycle for C = F_SIZE/P cycles per output.
module conv_param_mac #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int P            = 4,
  parameter int ACC_SIZE     = 21,
  parameter int SATURATE     = 0,
  parameter int KEEP_F       = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           s_valid_x,
  output logic                           s_ready_x,
  input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                           s_valid_f,
  output logic                           s_ready_f,
  input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
  output logic                           m_valid_y,
  input  logic                           m_ready_y,
  output logic signed [ACC_SIZE-1:0]     m_data_out_y,
  output logic                           y_last
);

  localparam int unsigned C    = F_SIZE / P;
  localparam int unsigned NY   = X_SIZE - F_SIZE + 1;
  localparam int unsigned PW   = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int unsigned AW   = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE);
  localparam int unsigned CNTW = $clog2(F_SIZE + 1);
  localparam int unsigned IW   = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
  localparam int unsigned CW   = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned OW   = (NY > 1) ? $clog2(NY) : 1;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNTW-1:0]           w_cnt_q, w_cnt_d;
  logic [CNTW-1:0]           f_cnt_q, f_cnt_d;
  logic [CW-1:0]             cyc_q, cyc_d;
  logic [OW-1:0]             out_cnt_q, out_cnt_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic signed [ACC_SIZE-1:0] y_q, y_d;
  logic                      y_last_q, y_last_d;
  logic signed [DATA_WIDTH_X-1:0] win_q  [F_SIZE];
  logic signed [DATA_WIDTH_X-1:0] win_d  [F_SIZE];
  logic signed [DATA_WIDTH_F-1:0] taps_q [F_SIZE];
  logic signed [DATA_WIDTH_F-1:0] taps_d [F_SIZE];

  logic                      x_hs, f_hs;
  logic signed [AW-1:0]      psum;
  logic signed [AW-1:0]      acc_fin;
  logic signed [ACC_SIZE-1:0] y_conv;
  logic [IW-1:0]             tap_idx;
  logic signed [PW-1:0]      xa, fa, prod;

  assign s_ready_x    = (state_q == LOAD) && (w_cnt_q < CNTW'(F_SIZE));
  assign s_ready_f    = (f_cnt_q < CNTW'(F_SIZE));
  assign m_valid_y    = (state_q == OUTPUT);
  assign m_data_out_y = y_q;
  assign y_last       = y_last_q;

  assign x_hs    = s_valid_x && s_ready_x;
  assign f_hs    = s_valid_f && s_ready_f;
  assign acc_fin = acc_q + psum;

  // Sum of the P window*tap products selected by the current compute cycle.
  always_comb begin
    psum    = '0;
    tap_idx = '0;
    xa      = '0;
    fa      = '0;
    prod    = '0;
    for (int unsigned p = 0; p < P; p++) begin
      tap_idx = IW'(int'(cyc_q) * P + p);
      xa      = PW'(win_q[tap_idx]);
      fa      = PW'(taps_q[tap_idx]);
      prod    = xa * fa;
      psum    = psum + AW'(prod);
    end
  end

  // Narrow the full-precision sum to the output width (clamp or wrap).
  if (AW > ACC_SIZE) begin : g_narrow
    logic ovf;
    always_comb begin
      ovf = (acc_fin[AW-1:ACC_SIZE-1] != '0) && (acc_fin[AW-1:ACC_SIZE-1] != '1);
      if ((SATURATE != 0) && ovf) begin
        y_conv = acc_fin[AW-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                               : {1'b0, {(ACC_SIZE-1){1'b1}}};
      end else begin
        y_conv = acc_fin[ACC_SIZE-1:0];
      end
    end
  end else begin : g_wide
    assign y_conv = ACC_SIZE'(acc_fin);
  end

  // Stream intake, FSM sequencing, accumulation and output capture.
  always_comb begin
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    f_cnt_d   = f_cnt_q;
    cyc_d     = cyc_q;
    out_cnt_d = out_cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_last_d  = y_last_q;
    win_d     = win_q;
    taps_d    = taps_q;

    if (f_hs) begin
      taps_d[f_cnt_q[IW-1:0]] = s_data_in_f;
      f_cnt_d                 = f_cnt_q + CNTW'(1);
    end

    if (x_hs) begin
      for (int unsigned j = 0; j < F_SIZE - 1; j++) begin
        win_d[j] = win_q[j+1];
      end
      win_d[F_SIZE-1] = s_data_in_x;
      w_cnt_d         = w_cnt_q + CNTW'(1);
    end

    case (state_q)
      LOAD: begin
        if ((w_cnt_q == CNTW'(F_SIZE)) && (f_cnt_q == CNTW'(F_SIZE))) begin
          state_d = COMPUTE;
          acc_d   = '0;
          cyc_d   = '0;
        end
      end
      COMPUTE: begin
        acc_d = acc_fin;
        if (cyc_q == CW'(C - 1)) begin
          state_d  = OUTPUT;
          y_d      = y_conv;
          y_last_d = (out_cnt_q == OW'(NY - 1));
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (m_ready_y) begin
          state_d  = LOAD;
          y_last_d = 1'b0;
          if (y_last_q) begin
            w_cnt_d   = '0;
            out_cnt_d = '0;
            if (KEEP_F == 0) begin
              f_cnt_d = '0;
            end
          end else begin
            // Oldest sample drops out logically; the next accepted sample
            // shifts the window by exactly one position.
            w_cnt_d   = CNTW'(F_SIZE - 1);
            out_cnt_d = out_cnt_q + OW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LOAD;
      w_cnt_q   <= '0;
      f_cnt_q   <= '0;
      cyc_q     <= '0;
      out_cnt_q <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_last_q  <= 1'b0;
      win_q     <= '{default: '0};
      taps_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      f_cnt_q   <= f_cnt_d;
      cyc_q     <= cyc_d;
      out_cnt_q <= out_cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_last_q  <= y_last_d;
      win_q     <= win_d;
      taps_q    <= taps_d;
    end
  end

endmodule

// File: tb/tb_conv_param_mac.sv
// Testbench for conv_param_mac: two instances (P=2 wrap/reload filter,
// P=4 saturate/keep filter) checked against a plain convolution model.
module tb_conv_param_mac;

  localparam int XS = 8;
  localparam int FS = 4;
  localparam int NY = XS - FS + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n = 2'b00;
  logic [1:0] vx = 2'b00;
  logic [1:0] vf = 2'b00;
  logic [1:0] ry = 2'b00;
  logic signed [7:0] dx [2];
  logic signed [7:0] df [2];

  logic rdx0, rdf0, vy0, yl0;
  logic rdx1, rdf1, vy1, yl1;
  logic signed [15:0] dy0, dy1;

  int n_chk  = 0;
  int n_pass = 0;
  int xv [XS];
  int fv [FS];

  conv_param_mac #(
    .DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS),
    .P(2), .ACC_SIZE(16), .SATURATE(0), .KEEP_F(0)
  ) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]),
    .s_valid_x(vx[0]), .s_ready_x(rdx0), .s_data_in_x(dx[0]),
    .s_valid_f(vf[0]), .s_ready_f(rdf0), .s_data_in_f(df[0]),
    .m_valid_y(vy0), .m_ready_y(ry[0]), .m_data_out_y(dy0), .y_last(yl0)
  );

  conv_param_mac #(
    .DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS),
    .P(4), .ACC_SIZE(16), .SATURATE(1), .KEEP_F(1)
  ) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]),
    .s_valid_x(vx[1]), .s_ready_x(rdx1), .s_data_in_x(dx[1]),
    .s_valid_f(vf[1]), .s_ready_f(rdf1), .s_data_in_f(df[1]),
    .m_valid_y(vy1), .m_ready_y(ry[1]), .m_data_out_y(dy1), .y_last(yl1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int g_rdx(input int n); return (n == 0) ? int'(rdx0) : int'(rdx1); endfunction
  function automatic int g_rdf(input int n); return (n == 0) ? int'(rdf0) : int'(rdf1); endfunction
  function automatic int g_vy (input int n); return (n == 0) ? int'(vy0)  : int'(vy1);  endfunction
  function automatic int g_yl (input int n); return (n == 0) ? int'(yl0)  : int'(yl1);  endfunction
  function automatic int g_dy (input int n); return (n == 0) ? int'(dy0)  : int'(dy1);  endfunction

  // Reference: direct convolution, then clamp or 16-bit two's-complement wrap.
  function automatic int model_y(input int k, input bit sat);
    int s = 0;
    for (int i = 0; i < FS; i++) s += xv[k+i] * fv[i];
    if (sat) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end else begin
      s = s & 32'h0000_FFFF;
      if (s >= 32768) s -= 65536;
    end
    return s;
  endfunction

  task automatic set_basic();
    for (int i = 0; i < XS; i++) xv[i] = i + 1;
    for (int i = 0; i < FS; i++) fv[i] = 1;
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < XS; i++) xv[i] = v;
    for (int i = 0; i < FS; i++) fv[i] = v;
  endtask

  task automatic set_rand_x();
    for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic set_rand_f();
    for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // One full vector on instance n. mode: 0 ready=1, 1 random ready,
  // 2 hold the first Y for 10 cycles. Must be entered at a negedge.
  task automatic run_vector(input int n, input bit send_f, input int mode, input bit gaps);
    bit  sat   = (n == 1);
    bit  keep  = (n == 1);
    int  c_lat = (n == 0) ? 3 : 2;
    int  exp_y [NY];
    time t_x = 0;
    time t_f = 0;
    time t_v = 0;
    time t_done;
    for (int k = 0; k < NY; k++) exp_y[k] = model_y(k, sat);
    fork
      begin : x_feed
        for (int i = 0; i < XS; i++) begin
          int b  = 0;
          bit hs = 1'b0;
          if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
          vx[n] = 1'b1;
          dx[n] = 8'(xv[i]);
          while (!hs && b < 400) begin
            hs = (g_rdx(n) == 1);
            if (hs && i == FS - 1) t_x = $time;
            if (keep && !send_f) check("f_ready_kept", g_rdf(n), 0);
            @(negedge clk);
            b++;
          end
          vx[n] = 1'b0;
          if (!hs) check("x_hs_timeout", 0, 1);
        end
      end
      begin : f_feed
        if (send_f) begin
          for (int i = 0; i < FS; i++) begin
            int b  = 0;
            bit hs = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            vf[n] = 1'b1;
            df[n] = 8'(fv[i]);
            while (!hs && b < 400) begin
              hs = (g_rdf(n) == 1);
              if (hs && i == FS - 1) t_f = $time;
              @(negedge clk);
              b++;
            end
            vf[n] = 1'b0;
            if (!hs) check("f_hs_timeout", 0, 1);
          end
        end
      end
      begin : y_sink
        int k     = 0;
        int b     = 0;
        int stall = 0;
        int prev  = 0;
        bit prev_stalled = 1'b0;
        bit seen  = 1'b0;
        bit r;
        while (k < NY && b < 1500) begin
          if (mode == 0) r = 1'b1;
          else if (mode == 1) r = 1'($urandom_range(0, 1));
          else r = !(k == 0 && stall < 10);
          ry[n] = r;
          if (g_vy(n) == 1) begin
            if (!seen) begin seen = 1'b1; t_v = $time; end
            if (prev_stalled) check("y_hold", g_dy(n), prev);
            check("x_blocked", g_rdx(n), 0);
            if (r) begin
              check("y_data", g_dy(n), exp_y[k]);
              check("y_last", g_yl(n), (k == NY - 1) ? 1 : 0);
              k++;
              prev_stalled = 1'b0;
            end else begin
              if (mode == 2) check("bp_first_y", g_dy(n), exp_y[0]);
              prev_stalled = 1'b1;
              prev = g_dy(n);
              stall++;
            end
          end
          @(negedge clk);
          b++;
        end
        ry[n] = 1'b0;
        if (k < NY) check("y_timeout", k, NY);
        else begin
          check("f_ready_after_last", g_rdf(n), keep ? 0 : 1);
          check("x_ready_after_last", g_rdx(n), 1);
          check("valid_after_last", g_vy(n), 0);
        end
      end
    join
    t_done = (t_x > t_f) ? t_x : t_f;
    check("latency_edges", int'((t_v - t_done) / 10) - 1, c_lat);
  endtask

  initial begin
    dx[0] = '0; dx[1] = '0; df[0] = '0; df[1] = '0;

    // Reset with junk traffic presented; it must be ignored.
    repeat (2) @(negedge clk);
    vx = 2'b11; vf = 2'b11; ry = 2'b11;
    dx[0] = 8'sd99; dx[1] = 8'sd99; df[0] = -8'sd7; df[1] = -8'sd7;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      check("rst_valid", g_vy(n), 0);
      check("rst_data", g_dy(n), 0);
      check("rst_last", g_yl(n), 0);
      check("rst_ready_x", g_rdx(n), 1);
      check("rst_ready_f", g_rdf(n), 1);
    end
    vx = 2'b00; vf = 2'b00; ry = 2'b00;
    @(negedge clk);
    rst_n = 2'b11;
    @(negedge clk);

    // Instance 0: P=2, wrap, filter reloaded per vector.
    set_basic();   run_vector(0, 1'b1, 0, 1'b0);
    set_basic();   run_vector(0, 1'b1, 2, 1'b0);
    set_const(127); run_vector(0, 1'b1, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      set_rand_x(); set_rand_f(); run_vector(0, 1'b1, 1, 1'b1);
    end
    set_basic();   run_vector(0, 1'b1, 0, 1'b0);

    // Reset asserted mid-COMPUTE: outputs clear at once, no partial Y later.
    for (int i = 0; i < FS; i++) begin
      vx[0] = 1'b1; vf[0] = 1'b1;
      dx[0] = 8'(xv[i]); df[0] = 8'(fv[i]);
      @(negedge clk);
    end
    vx[0] = 1'b0; vf[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check("midrst_valid", g_vy(0), 0);
    check("midrst_data", g_dy(0), 0);
    check("midrst_last", g_yl(0), 0);
    check("midrst_ready_x", g_rdx(0), 1);
    check("midrst_ready_f", g_rdf(0), 1);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_y", g_vy(0), 0);
    end
    set_basic();   run_vector(0, 1'b1, 0, 1'b0);

    // Instance 1: P=4, saturate, filter kept across vectors.
    set_basic();   run_vector(1, 1'b1, 0, 1'b0);
    set_basic();   run_vector(1, 1'b0, 1, 1'b1);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    set_const(127); run_vector(1, 1'b1, 0, 1'b0);
    set_rand_x();  run_vector(1, 1'b0, 1, 1'b1);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    set_rand_x(); set_rand_f(); run_vector(1, 1'b1, 1, 1'b1);
    set_rand_x();  run_vector(1, 1'b0, 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
